// File: rtl/onehot_decoder_buf.sv
// One-hot decoder for a priority-encoder index, followed by a small circular FIFO of decoded words.
// Codes are decoded when they are pushed, so the FIFO stores one-hot words (or all-zero).
module onehot_decoder_buf #(
  parameter int unsigned NUM_BITS = 3,
  parameter int unsigned DEPTH    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_BITS-1:0]      code_in,
  input  logic                     code_vld,
  output logic [(2**NUM_BITS)-1:0] sigOut,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [15:0]              xfer_cnt,
  output logic [7:0]               err_cnt
);

  localparam int unsigned OUT_W = 2 ** NUM_BITS;
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [OUT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wp;
  logic [PTR_W-1:0] rp;
  logic [OCC_W-1:0] occ;

  logic             push_c;
  logic             pop_c;
  logic             in_bad_c;
  logic [OUT_W-1:0] dec_c;

  // Handshake flags depend only on registered occupancy.
  assign in_ready  = (occ != OCC_W'(DEPTH));
  assign out_valid = (occ != '0);
  assign sigOut    = out_valid ? mem[rp] : '0;

  assign push_c = in_valid && in_ready;
  assign pop_c  = out_valid && out_ready;

  // Unknown-bit detection exists only in simulation; hardware never flags an error.
`ifdef SYNTHESIS
  assign in_bad_c = 1'b0;
`else
  assign in_bad_c = $isunknown({code_in, code_vld});
`endif

  always_comb begin
    dec_c = '0;
    if (!in_bad_c && (code_vld == 1'b1)) begin
      dec_c[code_in] = 1'b1;
    end
  end

  // Storage is not reset: it is only visible while occupancy is nonzero.
  always_ff @(posedge clk) begin
    if (rst_n && push_c) begin
      mem[wp] <= dec_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp       <= '0;
      rp       <= '0;
      occ      <= '0;
      xfer_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      if (push_c) begin
        wp <= (wp == PTR_W'(DEPTH - 1)) ? '0 : wp + PTR_W'(1);
        if (xfer_cnt != 16'hFFFF) begin
          xfer_cnt <= xfer_cnt + 16'd1;
        end
        if (in_bad_c && (err_cnt != 8'hFF)) begin
          err_cnt <= err_cnt + 8'd1;
        end
      end
      if (pop_c) begin
        rp <= (rp == PTR_W'(DEPTH - 1)) ? '0 : rp + PTR_W'(1);
      end
      case ({push_c, pop_c})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: doc/onehot_decoder_buf.md
ONEHOT_DECODER_BUF -- requirements
Module: onehot_decoder_buf

Interface
- REQ-001 The module SHALL have parameter NUM_BITS, default 3, meaning the encoded code width; the decoded width is 2**NUM_BITS.
- REQ-002 The module SHALL have parameter DEPTH, default 2, meaning the number of buffer entries; legal values are 2 through 8.
- REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-004 The module SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
- REQ-005 The module SHALL have port in_valid, input, 1 bit: an input code is offered.
- REQ-006 The module SHALL have port in_ready, output, 1 bit: the block can accept a code this cycle.
- REQ-007 The module SHALL have port code_in, input, NUM_BITS bits: the encoded index, the priority-encoder output.
- REQ-008 The module SHALL have port code_vld, input, 1 bit: 1 if the encoder saw a nonzero input, 0 if its input was all-zero.
- REQ-009 The module SHALL have port sigOut, output, 2**NUM_BITS bits: the decoded one-hot word, or all-zero.
- REQ-010 The module SHALL have port out_valid, output, 1 bit: sigOut holds a valid word.
- REQ-011 The module SHALL have port out_ready, input, 1 bit: the downstream consumer accepts sigOut.
- REQ-012 The module SHALL have port xfer_cnt, output, 16 bits: the number of input transfers accepted, saturating.
- REQ-013 The module SHALL have port err_cnt, output, 8 bits: the number of accepted codes with an X/Z bit on code_in or code_vld, saturating.

Function
- REQ-014 An input transfer SHALL occur on a rising edge when in_valid=1 and in_ready=1.
- REQ-015 An output transfer SHALL occur on a rising edge when out_valid=1 and out_ready=1.
- REQ-016 Decode rule: code_vld=1 SHALL yield sigOut with exactly bit code_in set; code_vld=0 SHALL yield all-zero, regardless of code_in.
- REQ-017 Decode SHALL happen at push time; the buffer SHALL store decoded words.
- REQ-018 The buffer SHALL be a circular FIFO with DEPTH entries, write pointer wp, read pointer rp, and occupancy count occ in 0..DEPTH.
- REQ-019 Pointers SHALL wrap from DEPTH-1 to 0.
- REQ-020 in_ready SHALL equal (occ != DEPTH), a registered-state function with no combinational path from out_ready.
- REQ-021 out_valid SHALL equal (occ != 0); sigOut SHALL equal the entry at rp when out_valid=1, and all-zero otherwise.
- REQ-022 Latency: a code accepted at edge N SHALL be visible at sigOut with out_valid=1 after edge N, when the buffer was empty; there is no same-cycle bypass.
- REQ-023 Push only SHALL give occ+1; pop only SHALL give occ-1; simultaneous push and pop SHALL leave occ unchanged, with both pointers advancing.
- REQ-024 When full, in_ready=0, so a pop in that cycle SHALL free a slot only from the next cycle.
- REQ-025 When empty, a pop SHALL be impossible because out_valid=0; out_ready is ignored.
- REQ-026 Buffer contents and ordering SHALL be strictly FIFO; sigOut SHALL hold stable while out_valid=1 and out_ready=0.
- REQ-027 xfer_cnt SHALL increment by 1 per input transfer and saturate at 16'hFFFF.
- REQ-028 On an input transfer where code_in or code_vld contains X/Z (reduction-XOR is X), the block SHALL increment err_cnt (saturating at 8'hFF) and store all-zero for that entry.
- REQ-029 The X/Z check SHALL be simulation-only behaviour; in synthesis err_cnt SHALL stay 0.
- REQ-030 Inputs other than rst_n SHALL be ignored while rst_n=0.

Reset
- REQ-031 On a rising edge with rst_n=0, the block SHALL set occ, wp, rp, xfer_cnt and err_cnt to 0.
- REQ-032 After reset, in_ready SHALL be 1, out_valid SHALL be 0, and sigOut SHALL be all-zero.
- REQ-033 Reset mid-operation SHALL discard all buffered entries; no entry SHALL appear after rst_n returns to 1.
- REQ-034 A transfer asserted in the reset cycle SHALL NOT be counted.
- REQ-035 Buffer storage SHALL need no reset, since it is never observable while empty.

Verification
- REQ-036 Sweep: out_ready=1, push code_in=0..7 with code_vld=1, one per cycle -> each output one cycle later is 8'b0000_0001 through 8'b1000_0000 in order; xfer_cnt=8.
- REQ-037 Zero case: code_vld=0, code_in=3'b101 -> sigOut=8'h00 with out_valid=1.
- REQ-038 Backpressure: out_ready=0, push codes 2, 5, then 7 -> in_ready=0 after two pushes and code 7 is not accepted; release out_ready -> outputs 8'h04 then 8'h20; xfer_cnt=2.
- REQ-039 Full plus simultaneous push/pop: occ=1 with in_valid=1 and out_ready=1 held for 20 random cycles -> occ stays 1 and output order matches input order across pointer wrap.
- REQ-040 Mid-stream reset: occ=2, drive rst_n=0 for 1 cycle -> out_valid=0, in_ready=1, xfer_cnt=0 next cycle; the stale entries never appear.
- REQ-041 X/Z input: code_in=3'bx01 accepted -> err_cnt=1, and that output entry is 8'h00.
